memwb_stage_ctrl: RTL and testbench

- Parametrised MEM/WB pipeline register with an integrated memory-access handshake FSM.
- Sits between the execute/address stage and writeback.
  - Latches the instruction payload on advance.
  - Issues a level request to the data memory port and holds the stage until the response arrives.
- Over the fixed-width stage it replaces, it adds: valid/bubble tracking, byte-lane enables, load-data capture with byte extraction, and an optional response timeout.

---
 rtl/memwb_stage_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_memwb_stage_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage_ctrl.sv
// ---------------------------------------------------------------------------
// memwb_stage_ctrl
//
// MEM/WB pipeline register with a built-in data-memory handshake FSM.
// On an accepted advance the instruction payload is latched.  For a load or
// a store, a level request is raised toward the data memory and the stage
// stalls (ready=0) until the response returns.  Load data is captured with
// byte-lane extraction.
//
// Optional build macro: MEMWB_TIMEOUT_EN
//   defined   : a WAIT-cycle counter aborts the access after TIMEOUT_CYCLES
//               cycles, sets a sticky err flag and clears rdata_out.
//   undefined : WAIT lasts until data_response arrives; err is tied to 0.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   advance, in_valid          advance strobe and slot-valid from upstream
//   pc_in/dest_in/imm_in/ctrl_in   instruction payload
//   mem_read_in/mem_write_in/byte_in   access type
//   addr_in, wdata_in          effective address and store data
//   data_response, rdata_in    memory completion (level) and read data
//   data_request               memory request, held until response
//   load_mar, load_mdr         single-cycle MAR / MDR load pulses
//   mem_addr/mem_wdata/mem_we/mem_byte_en   latched memory-side controls
//   out_valid, pc_out, dest_out, imm_out, alu_out, rdata_out, ctrl_out
//                              writeback-side view of the stage
//   ready                      stage can accept an advance
//   err                        sticky timeout flag
//
// State table
//   state  | meaning
//   S_IDLE | stage may accept an advance; no memory access outstanding
//   S_WAIT | request outstanding; stage stalled until response/timeout
// ---------------------------------------------------------------------------
module memwb_stage_ctrl #(
    parameter int DATA_W         = 16,
    parameter int REG_W          = 3,
    parameter int IMM_W          = 16,
    parameter int CTRL_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                advance,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [REG_W-1:0]    dest_in,
    input  logic [IMM_W-1:0]    imm_in,
    input  logic [CTRL_W-1:0]   ctrl_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                byte_in,
    input  logic [DATA_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic                data_response,
    input  logic [DATA_W-1:0]   rdata_in,
    output logic                data_request,
    output logic                load_mar,
    output logic                load_mdr,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_byte_en,
    output logic                out_valid,
    output logic [DATA_W-1:0]   pc_out,
    output logic [REG_W-1:0]    dest_out,
    output logic [IMM_W-1:0]    imm_out,
    output logic [DATA_W-1:0]   alu_out,
    output logic [DATA_W-1:0]   rdata_out,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic                ready,
    output logic                err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic accept;       // payload latch this cycle
    logic bubble;       // advance with an empty upstream slot
    logic take_mem;     // accepted instruction is a load or store
    logic complete;     // response accepted in WAIT
    logic expire;       // timeout abort in WAIT
    logic timeout_hit;

    logic op_read;
    logic op_byte;

    logic [LANE_W-1:0] in_lane;
    logic [LANE_W-1:0] rd_lane;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_value;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // load_mar is high exactly in the request-issue cycle, so it doubles as
    // the marker that keeps the response from being sampled in that cycle.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        bubble       = 1'b0;
        take_mem     = 1'b0;
        complete     = 1'b0;
        expire       = 1'b0;
        data_request = 1'b0;
        ready        = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (advance) begin
                    if (in_valid) begin
                        accept = 1'b1;
                        if (mem_read_in || mem_write_in) begin
                            take_mem   = 1'b1;
                            state_next = S_WAIT;
                        end
                    end else begin
                        bubble = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                data_request = 1'b1;
                if (data_response && !load_mar) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end else if (timeout_hit) begin
                    expire     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Optional wait timeout
    // -----------------------------------------------------------------------
`ifdef MEMWB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // The count equals the number of WAIT cycles already completed, so the
    // abort fires at the end of the TIMEOUT_CYCLES-th WAIT cycle.
    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (take_mem) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
    assign err                = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Byte-lane helpers
    // -----------------------------------------------------------------------
    assign in_lane  = addr_in[LANE_W-1:0];
    assign rd_lane  = mem_addr[LANE_W-1:0];
    assign rd_shift = rdata_in >> {rd_lane, 3'b000};
    assign rd_value = op_byte ? {{(DATA_W-8){1'b0}}, rd_shift[7:0]} : rdata_in;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_mar    <= 1'b0;
            load_mdr    <= 1'b0;
            out_valid   <= 1'b0;
            pc_out      <= '0;
            dest_out    <= '0;
            imm_out     <= '0;
            ctrl_out    <= '0;
            alu_out     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_byte_en <= '0;
            rdata_out   <= '0;
            op_read     <= 1'b0;
            op_byte     <= 1'b0;
        end else begin
            load_mar <= take_mem;
            load_mdr <= take_mem ? mem_write_in : (complete && op_read);

            if (bubble) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                out_valid <= 1'b1;
                pc_out    <= pc_in;
                dest_out  <= dest_in;
                imm_out   <= imm_in;
                ctrl_out  <= ctrl_in;
                alu_out   <= addr_in;
                mem_addr  <= addr_in;
                mem_we    <= mem_write_in;
                op_read   <= mem_read_in;
                op_byte   <= byte_in;
                mem_wdata <= byte_in ? {BE_W{wdata_in[7:0]}} : wdata_in;
                if (take_mem) begin
                    mem_byte_en <= byte_in ? (BE_W'(1) << in_lane) : {BE_W{1'b1}};
                end else begin
                    mem_byte_en <= '0;
                end
            end

            if (complete && op_read) begin
                rdata_out <= rd_value;
            end else if (expire) begin
                rdata_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memwb_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_memwb_stage_ctrl
//
// Directed bench for memwb_stage_ctrl with DATA_W=16.  Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_memwb_stage_ctrl;

`ifdef MEMWB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        advance;
    logic        in_valid;
    logic [15:0] pc_in;
    logic [2:0]  dest_in;
    logic [15:0] imm_in;
    logic [31:0] ctrl_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        byte_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        data_response;
    logic [15:0] rdata_in;
    logic        data_request;
    logic        load_mar;
    logic        load_mdr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_byte_en;
    logic        out_valid;
    logic [15:0] pc_out;
    logic [2:0]  dest_out;
    logic [15:0] imm_out;
    logic [15:0] alu_out;
    logic [15:0] rdata_out;
    logic [31:0] ctrl_out;
    logic        ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    memwb_stage_ctrl #(
        .DATA_W(16), .REG_W(3), .IMM_W(16), .CTRL_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .advance(advance), .in_valid(in_valid),
        .pc_in(pc_in), .dest_in(dest_in), .imm_in(imm_in), .ctrl_in(ctrl_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .byte_in(byte_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .data_response(data_response),
        .rdata_in(rdata_in), .data_request(data_request), .load_mar(load_mar),
        .load_mdr(load_mdr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_byte_en(mem_byte_en), .out_valid(out_valid),
        .pc_out(pc_out), .dest_out(dest_out), .imm_out(imm_out), .alu_out(alu_out),
        .rdata_out(rdata_out), .ctrl_out(ctrl_out), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        advance      = 1'b0;
        in_valid     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        byte_in      = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        pc_in         = '0;
        dest_in       = '0;
        imm_in        = '0;
        ctrl_in       = '0;
        addr_in       = '0;
        wdata_in      = '0;
        data_response = 1'b0;
        rdata_in      = '0;
        clear_op();

        // Reset state
        tick();
        tick();
        chk("rst_ready", ready, 1);
        chk("rst_req", data_request, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // ALU op
        advance = 1'b1; in_valid = 1'b1;
        pc_in = 16'h3000; dest_in = 3'd5; addr_in = 16'h1234;
        imm_in = 16'h0042; ctrl_in = 32'hDEAD_BEEF;
        tick();
        clear_op();
        chk("alu_pc", pc_out, 16'h3000);
        chk("alu_dest", dest_out, 5);
        chk("alu_out", alu_out, 16'h1234);
        chk("alu_imm", imm_out, 16'h0042);
        chk("alu_ctrl", ctrl_out, 32'hDEAD_BEEF);
        chk("alu_valid", out_valid, 1);
        chk("alu_ready", ready, 1);
        chk("alu_req", data_request, 0);
        chk("alu_mar", load_mar, 0);

        // Bubble: out_valid drops, payload holds
        advance = 1'b1; in_valid = 1'b0; pc_in = 16'h9999;
        tick();
        clear_op();
        chk("bub_valid", out_valid, 0);
        chk("bub_pc", pc_out, 16'h3000);

        // Word load, response asserted 3 cycles after the request cycle;
        // advance held high with new PCs throughout WAIT.
        advance = 1'b1; in_valid = 1'b1; mem_read_in = 1'b1;
        addr_in = 16'h4000; pc_in = 16'h3010; dest_in = 3'd2;
        tick();
        clear_op();
        chk("ld_req_c0", data_request, 1);
        chk("ld_ready_c0", ready, 0);
        chk("ld_mar_c0", load_mar, 1);
        chk("ld_mdr_c0", load_mdr, 0);
        chk("ld_be", mem_byte_en, 2'b11);
        chk("ld_addr", mem_addr, 16'h4000);
        for (int k = 1; k <= 3; k++) begin
            advance = 1'b1; in_valid = 1'b1; pc_in = 16'h5000 + 16'(k);
            tick();
            chk("ld_ready_wait", ready, 0);
            chk("ld_req_wait", data_request, 1);
            chk("ld_mar_wait", load_mar, 0);
            chk("ld_mdr_wait", load_mdr, 0);
            chk("stall_pc", pc_out, 16'h3010);
        end
        data_response = 1'b1; rdata_in = 16'hBEEF;
        advance = 1'b1; in_valid = 1'b1; pc_in = 16'h6000;
        tick();
        clear_op();
        data_response = 1'b0;
        chk("ld_ready_done", ready, 1);
        chk("ld_req_done", data_request, 0);
        chk("ld_mdr_done", load_mdr, 1);
        chk("ld_rdata", rdata_out, 16'hBEEF);
        chk("ld_pc_hold", pc_out, 16'h3010);
        chk("ld_valid", out_valid, 1);
        tick();
        chk("ld_mdr_once", load_mdr, 0);
        chk("ld_ready_after", ready, 1);

        // Byte load at lane 1 with the response already high in IDLE and the
        // issue cycle: it must not complete before the second WAIT cycle.
        advance = 1'b1; in_valid = 1'b1; mem_read_in = 1'b1; byte_in = 1'b1;
        addr_in = 16'h4001; pc_in = 16'h3020;
        data_response = 1'b1; rdata_in = 16'h7C00;
        tick();
        clear_op();
        chk("bl_ready_c0", ready, 0);
        chk("bl_be", mem_byte_en, 2'b10);
        tick();
        chk("bl_ready_c1", ready, 0);
        chk("bl_req_c1", data_request, 1);
        tick();
        data_response = 1'b0;
        chk("bl_ready_done", ready, 1);
        chk("bl_mdr", load_mdr, 1);
        chk("bl_rdata", rdata_out, 16'h007C);

        // Byte store at lane 1
        advance = 1'b1; in_valid = 1'b1; mem_write_in = 1'b1; byte_in = 1'b1;
        addr_in = 16'h4001; wdata_in = 16'h00A5; pc_in = 16'h3030;
        tick();
        clear_op();
        chk("bs_be", mem_byte_en, 2'b10);
        chk("bs_wdata", mem_wdata, 16'hA5A5);
        chk("bs_we", mem_we, 1);
        chk("bs_mdr_issue", load_mdr, 1);
        chk("bs_mar_issue", load_mar, 1);
        chk("bs_req", data_request, 1);
        tick();
        chk("bs_mdr_c1", load_mdr, 0);
        chk("bs_ready_c1", ready, 0);
        data_response = 1'b1;
        tick();
        data_response = 1'b0;
        chk("bs_ready_done", ready, 1);
        chk("bs_mdr_done", load_mdr, 0);
        chk("bs_rdata_keep", rdata_out, 16'h007C);

        // Load with no response
        advance = 1'b1; in_valid = 1'b1; mem_read_in = 1'b1;
        addr_in = 16'h4010; pc_in = 16'h3040;
        tick();
        clear_op();
`ifdef MEMWB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            chk("to_req_wait", data_request, 1);
            chk("to_err_wait", err, 0);
            tick();
        end
        chk("to_req", data_request, 0);
        chk("to_ready", ready, 1);
        chk("to_err", err, 1);
        chk("to_rdata", rdata_out, 0);
        chk("to_mdr", load_mdr, 0);
        tick();
        chk("to_err_sticky", err, 1);
`else
        for (int k = 0; k < 20; k++) begin
            chk("nto_req_wait", data_request, 1);
            chk("nto_err", err, 0);
            tick();
        end
        data_response = 1'b1; rdata_in = 16'h1357;
        tick();
        data_response = 1'b0;
        chk("nto_ready", ready, 1);
        chk("nto_rdata", rdata_out, 16'h1357);
        chk("nto_err_done", err, 0);
`endif

        // Reset in the middle of WAIT
        advance = 1'b1; in_valid = 1'b1; mem_read_in = 1'b1;
        addr_in = 16'h4002; pc_in = 16'h3050;
        tick();
        clear_op();
        chk("rw_req_before", data_request, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_req_async", data_request, 0);
        chk("rw_ready_async", ready, 1);
        chk("rw_valid_async", out_valid, 0);
        chk("rw_err_async", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        data_response = 1'b1; rdata_in = 16'hFFFF;
        tick();
        chk("rw_mdr_1", load_mdr, 0);
        chk("rw_req_1", data_request, 0);
        tick();
        data_response = 1'b0;
        chk("rw_mdr_2", load_mdr, 0);
        chk("rw_rdata", rdata_out, 0);
        chk("rw_ready", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
